// File: rtl/platform_pkg.sv
// Shared constants and types for the platform kinematics slice:
// anchor geometry, fixed-point formats and the rotator FSM states.
package platform_pkg;

  localparam int unsigned R_FRAC    = 14;
  localparam int unsigned P_FRAC    = 4;
  localparam int unsigned R_W       = 16;
  localparam int unsigned P_W       = 16;
  localparam int unsigned PROD_W    = R_W + P_W;
  localparam int unsigned SUM_W     = PROD_W + 2;
  localparam int unsigned N_ANCHORS = 3;

  // Anchor points in Q12.4 mm; all lie in the z = 0 plane
  localparam logic signed [P_W-1:0] ANCHOR_X [0:2] = '{16'sd1600, -16'sd800, -16'sd800};
  localparam logic signed [P_W-1:0] ANCHOR_Y [0:2] = '{16'sd0, 16'sd1386, -16'sd1386};
  localparam logic signed [P_W-1:0] ANCHOR_Z [0:2] = '{16'sd0, 16'sd0, 16'sd0};

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/dot3_q14.sv
// Combinational 3-term dot product: Q2.14 row times Q12.4 vector,
// floor-shifted back to Q12.4 and saturated to 16 bits.
module dot3_q14
  import platform_pkg::R_W;
  import platform_pkg::P_W;
  import platform_pkg::PROD_W;
  import platform_pkg::SUM_W;
#(
  parameter int unsigned R_FRAC = platform_pkg::R_FRAC
) (
  input  logic signed [R_W-1:0] r0,
  input  logic signed [R_W-1:0] r1,
  input  logic signed [R_W-1:0] r2,
  input  logic signed [P_W-1:0] a0,
  input  logic signed [P_W-1:0] a1,
  input  logic signed [P_W-1:0] a2,
  output logic signed [P_W-1:0] dot_c
);

  localparam logic signed [SUM_W-1:0] SAT_MAX = 34'sd32767;
  localparam logic signed [SUM_W-1:0] SAT_MIN = -34'sd32768;

  logic signed [PROD_W-1:0] p0, p1, p2;
  logic signed [SUM_W-1:0]  sum, shr;

  always_comb begin
    p0  = r0 * a0;
    p1  = r1 * a1;
    p2  = r2 * a2;
    sum = SUM_W'(p0) + SUM_W'(p1) + SUM_W'(p2);
    shr = sum >>> R_FRAC;
    if (shr > SAT_MAX) begin
      dot_c = 16'sh7FFF;
    end else if (shr < SAT_MIN) begin
      dot_c = 16'sh8000;
    end else begin
      dot_c = shr[P_W-1:0];
    end
  end

endmodule

// File: rtl/anchor_rotator.sv
// Rotates the three platform anchors by a latched 3x3 matrix, one matrix
// row per clock through a single shared dot-product unit.
module anchor_rotator
  import platform_pkg::R_W;
  import platform_pkg::P_W;
  import platform_pkg::ANCHOR_X;
  import platform_pkg::ANCHOR_Y;
  import platform_pkg::ANCHOR_Z;
  import platform_pkg::state_t;
  import platform_pkg::IDLE;
  import platform_pkg::RUN;
#(
  parameter int unsigned R_FRAC = platform_pkg::R_FRAC
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  validIn,
  input  logic signed [R_W-1:0] R11,
  input  logic signed [R_W-1:0] R12,
  input  logic signed [R_W-1:0] R13,
  input  logic signed [R_W-1:0] R21,
  input  logic signed [R_W-1:0] R22,
  input  logic signed [R_W-1:0] R23,
  input  logic signed [R_W-1:0] R31,
  input  logic signed [R_W-1:0] R32,
  input  logic signed [R_W-1:0] R33,
  output logic signed [P_W-1:0] px,
  output logic signed [P_W-1:0] py,
  output logic signed [P_W-1:0] pz,
  output logic [1:0]            anchorIdx,
  output logic                  validOut,
  output logic                  done,
  output logic                  busy,
  output logic                  overrun
);

  state_t state, state_nxt;
  logic [1:0] row, row_nxt;
  logic [1:0] anchor, anchor_nxt;
  logic signed [R_W-1:0] r_q [9];
  logic signed [R_W-1:0] r_nxt [9];

  logic signed [P_W-1:0] px_nxt, py_nxt, pz_nxt;
  logic [1:0]            idx_nxt;
  logic                  valid_nxt, done_nxt, busy_nxt, overrun_nxt;

  logic signed [R_W-1:0] ra0, ra1, ra2;
  logic signed [P_W-1:0] aa0, aa1, aa2;
  logic signed [P_W-1:0] dot;

  // Row select from the latched matrix
  always_comb begin
    ra0 = r_q[0];
    ra1 = r_q[1];
    ra2 = r_q[2];
    case (row)
      2'd1: begin
        ra0 = r_q[3];
        ra1 = r_q[4];
        ra2 = r_q[5];
      end
      2'd2: begin
        ra0 = r_q[6];
        ra1 = r_q[7];
        ra2 = r_q[8];
      end
      default: ;
    endcase
  end

  // Anchor select
  always_comb begin
    aa0 = ANCHOR_X[0];
    aa1 = ANCHOR_Y[0];
    aa2 = ANCHOR_Z[0];
    case (anchor)
      2'd1: begin
        aa0 = ANCHOR_X[1];
        aa1 = ANCHOR_Y[1];
        aa2 = ANCHOR_Z[1];
      end
      2'd2: begin
        aa0 = ANCHOR_X[2];
        aa1 = ANCHOR_Y[2];
        aa2 = ANCHOR_Z[2];
      end
      default: ;
    endcase
  end

  dot3_q14 #(.R_FRAC(R_FRAC)) u_dot (
    .r0    (ra0),
    .r1    (ra1),
    .r2    (ra2),
    .a0    (aa0),
    .a1    (aa1),
    .a2    (aa2),
    .dot_c (dot)
  );

  // Next-state and output logic
  always_comb begin
    state_nxt   = state;
    row_nxt     = row;
    anchor_nxt  = anchor;
    r_nxt       = r_q;
    px_nxt      = px;
    py_nxt      = py;
    pz_nxt      = pz;
    idx_nxt     = anchorIdx;
    valid_nxt   = 1'b0;
    done_nxt    = 1'b0;
    busy_nxt    = busy;
    overrun_nxt = overrun;
    case (state)
      IDLE: begin
        if (validIn) begin
          r_nxt      = '{R11, R12, R13, R21, R22, R23, R31, R32, R33};
          busy_nxt   = 1'b1;
          row_nxt    = 2'd0;
          anchor_nxt = 2'd0;
          state_nxt  = RUN;
        end
      end
      RUN: begin
        if (validIn) overrun_nxt = 1'b1;
        case (row)
          2'd0:    px_nxt = dot;
          2'd1:    py_nxt = dot;
          default: pz_nxt = dot;
        endcase
        if (row == 2'd2) begin
          valid_nxt = 1'b1;
          idx_nxt   = anchor;
          row_nxt   = 2'd0;
          if (anchor == 2'd2) begin
            done_nxt   = 1'b1;
            busy_nxt   = 1'b0;
            anchor_nxt = 2'd0;
            state_nxt  = IDLE;
          end else begin
            anchor_nxt = anchor + 2'd1;
          end
        end else begin
          row_nxt = row + 2'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      row       <= 2'd0;
      anchor    <= 2'd0;
      r_q       <= '{default: '0};
      px        <= '0;
      py        <= '0;
      pz        <= '0;
      anchorIdx <= 2'd0;
      validOut  <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_nxt;
      row       <= row_nxt;
      anchor    <= anchor_nxt;
      r_q       <= r_nxt;
      px        <= px_nxt;
      py        <= py_nxt;
      pz        <= pz_nxt;
      anchorIdx <= idx_nxt;
      validOut  <= valid_nxt;
      done      <= done_nxt;
      busy      <= busy_nxt;
      overrun   <= overrun_nxt;
    end
  end

endmodule

// File: tb/tb_anchor_rotator.sv
// Directed self-checking bench for anchor_rotator.
module tb_anchor_rotator;

  logic clock = 1'b0;
  logic reset;
  logic validIn;
  logic signed [15:0] R11, R12, R13, R21, R22, R23, R31, R32, R33;
  logic signed [15:0] px, py, pz;
  logic [1:0] anchorIdx;
  logic validOut, done, busy, overrun;

  anchor_rotator dut (
    .clock     (clock),
    .reset     (reset),
    .validIn   (validIn),
    .R11       (R11),
    .R12       (R12),
    .R13       (R13),
    .R21       (R21),
    .R22       (R22),
    .R23       (R23),
    .R31       (R31),
    .R32       (R32),
    .R33       (R33),
    .px        (px),
    .py        (py),
    .pz        (pz),
    .anchorIdx (anchorIdx),
    .validOut  (validOut),
    .done      (done),
    .busy      (busy),
    .overrun   (overrun)
  );

  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int last_done = 0;

  int n_got;
  int got_px [3];
  int got_py [3];
  int got_pz [3];
  int got_idx [3];
  int got_edge [3];
  int got_done [3];

  logic signed [15:0] ident [9];
  logic signed [15:0] zrot  [9];
  logic signed [15:0] flr   [9];
  logic signed [15:0] zero  [9];

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic drive_r(input logic signed [15:0] m [9]);
    R11 = m[0]; R12 = m[1]; R13 = m[2];
    R21 = m[3]; R22 = m[4]; R23 = m[5];
    R31 = m[6]; R32 = m[7]; R33 = m[8];
  endtask

  // Accept at edge 0, then observe edges 1..9; optional stray validIn at pulse_at
  task automatic run(input logic signed [15:0] m [9], input int pulse_at);
    n_got = 0;
    drive_r(m);
    validIn = 1'b1;
    tick();
    validIn = 1'b0;
    drive_r(zero);
    chk("busy_after_accept", int'(busy), 1);
    for (int k = 1; k <= 9; k++) begin
      if (k == pulse_at) begin
        drive_r(ident);
        validIn = 1'b1;
      end
      tick();
      validIn = 1'b0;
      drive_r(zero);
      if (validOut) begin
        if (n_got < 3) begin
          got_px[n_got]   = int'(px);
          got_py[n_got]   = int'(py);
          got_pz[n_got]   = int'(pz);
          got_idx[n_got]  = int'(anchorIdx);
          got_edge[n_got] = k;
          got_done[n_got] = int'(done);
        end
        n_got++;
      end
      if (done) last_done = cyc;
    end
    chk("busy_after_done", int'(busy), 0);
    chk("strobe_count", n_got, 3);
  endtask

  task automatic chk_anchor(input string pfx, input int i,
                            input int ex, input int ey, input int ez);
    chk($sformatf("%s_a%0d_px", pfx, i), got_px[i], ex);
    chk($sformatf("%s_a%0d_py", pfx, i), got_py[i], ey);
    chk($sformatf("%s_a%0d_pz", pfx, i), got_pz[i], ez);
    chk($sformatf("%s_a%0d_idx", pfx, i), got_idx[i], i);
    chk($sformatf("%s_a%0d_edge", pfx, i), got_edge[i], 3 * (i + 1));
    chk($sformatf("%s_a%0d_done", pfx, i), got_done[i], (i == 2) ? 1 : 0);
  endtask

  task automatic chk_identity(input string pfx);
    chk_anchor(pfx, 0, 1600, 0, 0);
    chk_anchor(pfx, 1, -800, 1386, 0);
    chk_anchor(pfx, 2, -800, -1386, 0);
  endtask

  task automatic chk_zrot(input string pfx);
    chk_anchor(pfx, 0, 0, 1600, 0);
    chk_anchor(pfx, 1, -1386, -800, 0);
    chk_anchor(pfx, 2, 1386, -800, 0);
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_px"}, int'(px), 0);
    chk({pfx, "_py"}, int'(py), 0);
    chk({pfx, "_pz"}, int'(pz), 0);
    chk({pfx, "_idx"}, int'(anchorIdx), 0);
    chk({pfx, "_valid"}, int'(validOut), 0);
    chk({pfx, "_done"}, int'(done), 0);
    chk({pfx, "_busy"}, int'(busy), 0);
    chk({pfx, "_overrun"}, int'(overrun), 0);
  endtask

  initial begin
    int d1;
    int strays;
    ident = '{16'sd16384, 16'sd0, 16'sd0, 16'sd0, 16'sd16384, 16'sd0, 16'sd0, 16'sd0, 16'sd16384};
    zrot  = '{16'sd0, -16'sd16384, 16'sd0, 16'sd16384, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd16384};
    flr   = '{-16'sd1, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0};
    zero  = '{default: 16'sd0};

    reset   = 1'b0;
    validIn = 1'b0;
    drive_r(zero);
    tick();
    tick();
    chk_all_zero("reset");
    reset = 1'b1;
    tick();

    run(ident, 0);
    chk_identity("ident");

    run(zrot, 0);
    chk_zrot("zrot");

    // -x/16384 floors to -1 for x=1600; +800/16384 floors to 0
    run(flr, 0);
    chk_anchor("floor", 0, -1, 0, 0);
    chk_anchor("floor", 1, 0, 0, 0);
    chk_anchor("floor", 2, 0, 0, 0);
    chk("no_overrun_yet", int'(overrun), 0);

    run(zrot, 4);
    chk_zrot("ovr");
    chk("overrun_set", int'(overrun), 1);

    // Abort mid-run with reset sampled at edge 5
    drive_r(ident);
    validIn = 1'b1;
    tick();
    validIn = 1'b0;
    drive_r(zero);
    for (int k = 1; k <= 4; k++) tick();
    chk("pre_reset_px", int'(px), -800);
    reset = 1'b0;
    tick();
    chk_all_zero("abort");
    reset = 1'b1;
    strays = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (validOut) strays++;
    end
    chk("no_valid_after_abort", strays, 0);

    run(ident, 0);
    chk_identity("rerun");
    d1 = last_done;

    run(ident, 0);
    chk_identity("b2b");
    chk("done_spacing", last_done - d1, 10);
    chk("b2b_overrun", int'(overrun), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
